// File: rtl/axi_apb_pkg.sv
// Shared types and constants for the AXI-to-APB read and write bridges.
package axi_apb_pkg;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_SETUP  = 2'd1,
    RD_ACCESS = 2'd2,
    RD_RESP   = 2'd3
  } rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned DEFAULT_BURST_LEN = 4;
  localparam int unsigned DEFAULT_ADDR_STEP = 4;

endpackage

// File: rtl/axi_to_apb_read_bridge.sv
// AXI read-address/read-data to APB read bridge: each accepted AR issues
// BURST_LEN sequential APB reads, returning one R beat per APB transfer.
module axi_to_apb_read_bridge
  import axi_apb_pkg::*;
#(
  parameter int unsigned BURST_LEN = DEFAULT_BURST_LEN,
  parameter int unsigned ADDR_STEP = DEFAULT_ADDR_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  // Beat counter covers the legal burst range 1..16.
  localparam int unsigned CNT_W = 4;

  rd_state_t          state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [CNT_W-1:0]   beat_q, beat_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [1:0]         rresp_q, rresp_d;
  logic               rlast_q, rlast_d;
  logic               arready_q, arready_d;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RD_IDLE:   if (arvalid && arready_q) state_d = RD_SETUP;
      RD_SETUP:  state_d = RD_ACCESS;
      RD_ACCESS: if (PREADY) state_d = RD_RESP;
      RD_RESP:   if (rready) state_d = rlast_q ? RD_IDLE : RD_SETUP;
      default:   state_d = RD_IDLE;
    endcase
  end

  // Output decode from state only; PWRITE is never driven high.
  always_comb begin
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    rvalid  = 1'b0;
    unique case (state_q)
      RD_SETUP:  PSEL = 1'b1;
      RD_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
      end
      RD_RESP:   rvalid = 1'b1;
      default:   ;
    endcase
  end

  // Datapath next values: address/beat tracking and R-beat capture.
  always_comb begin
    addr_d  = addr_q;
    beat_d  = beat_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    rlast_d = rlast_q;
    unique case (state_q)
      RD_IDLE: begin
        if (arvalid && arready_q) begin
          addr_d = araddr;
          beat_d = '0;
        end
      end
      RD_ACCESS: begin
        if (PREADY) begin
          rdata_d = PRDATA;
          rresp_d = PSLVERR ? RESP_SLVERR : RESP_OKAY;
          rlast_d = (beat_q == CNT_W'(BURST_LEN - 1));
        end
      end
      RD_RESP: begin
        if (rready && !rlast_q) begin
          addr_d = addr_q + 32'(ADDR_STEP);
          beat_d = beat_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    // Registered so arready stays low while reset is held.
    arready_d = (state_d == RD_IDLE);
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      beat_q    <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
      arready_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      beat_q    <= beat_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      arready_q <= arready_d;
    end
  end

  assign arready = arready_q;
  assign PADDR   = addr_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

endmodule
